// File: rtl/edge_bbox_overlay.sv
// Edge-map statistics (count + bounding box) with a rectangle overlay of the previous frame's box.
// Optional centre crosshair enabled by defining EDGE_BBOX_CROSSHAIR_EN.
module edge_bbox_overlay #(
   parameter logic [10:0] IMG_HDISP = 11'd1280,
   parameter logic [10:0] IMG_VDISP = 11'd720,
   parameter logic [15:0] BOX_COLOR = 16'hF800
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        EN,
   input  logic        pre_vs,
   input  logic        pre_de,
   input  logic [15:0] pre_img,
   output logic        post_vs,
   output logic        post_de,
   output logic [15:0] post_img,
   output logic        box_valid,
   output logic [10:0] box_xmin,
   output logic [10:0] box_xmax,
   output logic [10:0] box_ymin,
   output logic [10:0] box_ymax,
   output logic [20:0] edge_count
);

   logic        r_vs_d, r_de_d;
   logic [10:0] r_x, r_y;
   logic [10:0] r_acc_xmin, r_acc_xmax, r_acc_ymin, r_acc_ymax;
   logic [20:0] r_acc_cnt;
   logic        r_box_valid;
   logic [10:0] r_box_xmin, r_box_xmax, r_box_ymin, r_box_ymax;
   logic [20:0] r_edge_count;
   logic [15:0] r_post_img;

   logic        w_fs, w_fall, w_hit;
   logic [10:0] w_x, w_y;
   logic [10:0] w_base_xmin, w_base_xmax, w_base_ymin, w_base_ymax;
   logic [20:0] w_base_cnt;
   logic        w_in_xrange, w_in_yrange, w_border, w_paint;

   assign w_fs   = pre_vs & ~r_vs_d;
   assign w_fall = r_de_d & ~pre_de;
   assign w_hit  = pre_de & pre_img[0];

   // A pixel coincident with frame start is (0,0) of the new frame.
   assign w_x = w_fs ? 11'd0 : r_x;
   assign w_y = w_fs ? 11'd0 : r_y;

   assign w_base_xmin = w_fs ? 11'h7FF : r_acc_xmin;
   assign w_base_xmax = w_fs ? 11'h000 : r_acc_xmax;
   assign w_base_ymin = w_fs ? 11'h7FF : r_acc_ymin;
   assign w_base_ymax = w_fs ? 11'h000 : r_acc_ymax;
   assign w_base_cnt  = w_fs ? 21'd0   : r_acc_cnt;

   assign w_in_xrange = (w_x >= r_box_xmin) && (w_x <= r_box_xmax);
   assign w_in_yrange = (w_y >= r_box_ymin) && (w_y <= r_box_ymax);
   assign w_border    = (((w_x == r_box_xmin) || (w_x == r_box_xmax)) && w_in_yrange) ||
                        (((w_y == r_box_ymin) || (w_y == r_box_ymax)) && w_in_xrange);

`ifdef EDGE_BBOX_CROSSHAIR_EN
   logic [10:0] r_cx, r_cy;
   logic [11:0] w_cx_sum, w_cy_sum;
   logic        w_cross;

   assign w_cx_sum = {1'b0, r_acc_xmin} + {1'b0, r_acc_xmax};
   assign w_cy_sum = {1'b0, r_acc_ymin} + {1'b0, r_acc_ymax};
   assign w_cross  = ((w_x == r_cx) && w_in_yrange) || ((w_y == r_cy) && w_in_xrange);
   assign w_paint  = w_border | w_cross;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cx <= '0;
         r_cy <= '0;
      end else if (w_fs) begin
         r_cx <= 11'(w_cx_sum >> 1);
         r_cy <= 11'(w_cy_sum >> 1);
      end
   end
`else
   assign w_paint = w_border;
`endif

   // Position counters, saturating for oversize lines/frames.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vs_d <= 1'b0;
         r_de_d <= 1'b0;
         r_x    <= '0;
         r_y    <= '0;
      end else begin
         r_vs_d <= pre_vs;
         r_de_d <= pre_de;
         if (pre_de)
            r_x <= (w_x < IMG_HDISP - 11'd1) ? w_x + 11'd1 : w_x;
         else if (w_fall || w_fs)
            r_x <= '0;
         if (w_fs)
            r_y <= '0;
         else if (w_fall && (r_y < IMG_VDISP - 11'd1))
            r_y <= r_y + 11'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc_xmin <= 11'h7FF;
         r_acc_xmax <= '0;
         r_acc_ymin <= 11'h7FF;
         r_acc_ymax <= '0;
         r_acc_cnt  <= '0;
      end else if (w_hit) begin
         r_acc_xmin <= (w_x < w_base_xmin) ? w_x : w_base_xmin;
         r_acc_xmax <= (w_x > w_base_xmax) ? w_x : w_base_xmax;
         r_acc_ymin <= (w_y < w_base_ymin) ? w_y : w_base_ymin;
         r_acc_ymax <= (w_y > w_base_ymax) ? w_y : w_base_ymax;
         r_acc_cnt  <= (w_base_cnt == 21'h1FFFFF) ? w_base_cnt : w_base_cnt + 21'd1;
      end else begin
         r_acc_xmin <= w_base_xmin;
         r_acc_xmax <= w_base_xmax;
         r_acc_ymin <= w_base_ymin;
         r_acc_ymax <= w_base_ymax;
         r_acc_cnt  <= w_base_cnt;
      end
   end

   // Latched statistics take the pre-reload accumulator values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_box_valid  <= 1'b0;
         r_box_xmin   <= '0;
         r_box_xmax   <= '0;
         r_box_ymin   <= '0;
         r_box_ymax   <= '0;
         r_edge_count <= '0;
      end else if (w_fs) begin
         r_box_valid  <= (r_acc_cnt != 21'd0);
         r_box_xmin   <= r_acc_xmin;
         r_box_xmax   <= r_acc_xmax;
         r_box_ymin   <= r_acc_ymin;
         r_box_ymax   <= r_acc_ymax;
         r_edge_count <= r_acc_cnt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_post_img <= '0;
      else if (!pre_de)
         r_post_img <= '0;
      else if (EN && r_box_valid && w_paint)
         r_post_img <= BOX_COLOR;
      else
         r_post_img <= pre_img;
   end

   assign post_vs    = r_vs_d;
   assign post_de    = r_de_d;
   assign post_img   = r_post_img;
   assign box_valid  = r_box_valid;
   assign box_xmin   = r_box_xmin;
   assign box_xmax   = r_box_xmax;
   assign box_ymin   = r_box_ymin;
   assign box_ymax   = r_box_ymax;
   assign edge_count = r_edge_count;

endmodule

// File: doc/edge_bbox_overlay.md
# edge_bbox_overlay

Downstream consumer of the Sobel edge-detector output in the DVP video path. It measures each frame's binary edge map: edge-pixel count and the bounding box of all edge pixels. At each frame start it latches those results and draws the previous frame's box as a coloured rectangle over the passing video. The output feeds the display/framebuffer writer; the statistics feed software registers.

## Interface
- IMG_HDISP, 11'd1280, active pixels per line
- IMG_VDISP, 11'd720, active lines per frame
- BOX_COLOR, 16'hF800, RGB565 colour of overlay pixels

- clk  in  1  video pixel clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- EN  in  1  overlay enable; statistics run regardless
- pre_vs  in  1  frame sync from edge detector; rising edge = frame start
- pre_de  in  1  pixel valid
- pre_img  in  16  pixel; 16'hFFFF = edge, 16'h0000 = non-edge; edge test uses bit 0 only
- post_vs  out  1  pre_vs delayed 1 cycle
- post_de  out  1  pre_de delayed 1 cycle
- post_img  out  16  video with overlay
- box_valid  out  1  latched frame contained ≥1 edge pixel
- box_xmin, box_xmax  out  11 each  latched horizontal bounds, inclusive
- box_ymin, box_ymax  out  11 each  latched vertical bounds, inclusive
- edge_count  out  21  latched edge-pixel count

## Operation
- Position counters x, y are 11 bits each.
  - x: +1 per de cycle; cleared on de falling edge.
  - y: +1 on de falling edge; cleared on frame start.
  - x saturates at IMG_HDISP-1 and y at IMG_VDISP-1 for oversize lines or frames. Saturated pixels are still counted.
- Frame start is fs = pre_vs & ~vs_d, where vs_d is pre_vs registered.
- Accumulators (acc_xmin, acc_xmax, acc_ymin, acc_ymax, acc_cnt):
  - On each de cycle with pre_img[0]=1: min/max update with the current (x,y), and acc_cnt +1.
  - acc_cnt saturates at 21'h1FFFFF.
- On fs:
  - Outputs latch the accumulators.
  - box_valid is set to (acc_cnt != 0).
  - Accumulators reload: min = 11'h7FF, max = 0, cnt = 0.
- fs coincident with de: the latch takes the old accumulators. That pixel is the first pixel, (0,0), of the new frame and updates the freshly reloaded accumulators.
- Overlay, using the latched box. A pixel is on the border when:
  - x ∈ {box_xmin, box_xmax} and box_ymin ≤ y ≤ box_ymax, or
  - y ∈ {box_ymin, box_ymax} and box_xmin ≤ x ≤ box_xmax.
- post_img selection:
  - BOX_COLOR when EN & box_valid & pre_de & border.
  - Otherwise pre_img when pre_de.
  - Otherwise 16'h0000.
- Degenerate boxes (a single pixel, or a single row/column) draw as a point or line.
- EN changes take effect on the next pixel. Statistics are unaffected by EN.

## Timing
- Video latency is exactly 1 cycle on post_vs, post_de and post_img, all registered.
- Latched statistics change on the clock edge ending the first cycle with pre_vs high. They are visible from the second vs-high cycle and are stable for the rest of the frame.
- The overlay in frame N shows the box of frame N-1.
- The first frame after reset shows no box, because box_valid=0.
- Reset values:
  - All outputs 0.
  - vs_d, x, y = 0.
  - acc_xmin = acc_ymin = 11'h7FF; acc_xmax = acc_ymax = 0; acc_cnt = 0.
- Reset asserted mid-frame clears everything immediately. The partially accumulated frame is discarded.
- vs held high over several cycles generates a single fs. de occurring during vs high is counted normally.

## Configuration
- EDGE_BBOX_CROSSHAIR_EN defined:
  - Also paint BOX_COLOR on the centre column cx = (box_xmin+box_xmax)>>1 for box_ymin ≤ y ≤ box_ymax.
  - Also paint the centre row cy = (box_ymin+box_ymax)>>1 for box_xmin ≤ x ≤ box_xmax.
  - cx and cy are computed with a 12-bit sum, then truncated to 11 bits.
  - Same gating as the border: EN & box_valid & pre_de.
  - cx and cy are registered at fs time, so no latency change.
- Undefined: border only, and no centre logic is synthesized.

## Test plan
Bench parameters: IMG_HDISP=8, IMG_VDISP=6, BOX_COLOR=16'hF800.
- Reset then one all-zero frame, then a second fs → box_valid=0, edge_count=0. post_img equals pre_img, delayed 1 cycle.
- Frame with edges at (2,1) and (5,4), then fs → box_xmin=2, box_xmax=5, box_ymin=1, box_ymax=4, edge_count=2, box_valid=1.
- Next frame, all-zero input, EN=1 → 16'hF800 on x=2 or 5 for y=1..4, and on y=1 or 4 for x=2..5; all other pixels 0. With the crosshair macro, also x=3 (y=1..4) and y=2 (x=2..5).
- Same frame with EN=0 → post_img = pre_img everywhere; statistics still update at the following fs.
- fs coincident with an edge pixel at de → latched values are from the old frame; next latch includes (0,0), giving xmin=0 and ymin=0.
- rst_n pulsed low mid-frame after 3 edge pixels → all outputs 0 immediately; the next fs latches edge_count=0, box_valid=0.
